mmio_pwm_bank: RTL
==================

// Module: mmio_pwm_bank
// PURPOSE
//   Memory-mapped N-channel PWM output bank, successor to the fixed on/off LED/RGB bits in memory.
//   Sits on the core's data bus beside memory; decodes its own address window.
//   Register writes use the store funct3. Reads return one cycle later, like read_data_clocked.
//   Drives board LEDs and RGB pins with programmable duty, shared prescaler and glitch-free updates.
// PARAMETERS
//   NUM_CH     4             number of PWM channels, 1..16
//   PWM_BITS   8             counter/duty width, 1..16; period = 2^PWM_BITS ticks
//   BASE_ADDR  32'h0000_2000 window base, aligned to 128 bytes
//   ACTIVE_LOW 1'b1          1: pwm_out inverted (board LED/RGB pins are active-low)
// PORTS
//   clk       in   1         single clock; all logic on posedge
//   reset     in   1         synchronous, active-high
//   wr_en     in   1         store strobe for the address on addr
//   funct3    in   3         store size: 000 sb, 001 sh, 010 sw; other codes ignored
//   addr      in   32        byte address (shared read/write)
//   wdata     in   32        store data; the value in the addressed lane(s) is used
//   rdata     out  32        registered read data for the previous cycle's addr
//   hit       out  1         registered: the previous cycle's addr was inside the window
//   pwm_out   out  NUM_CH    registered PWM pins, polarity set by ACTIVE_LOW
// BEHAVIOUR
//   Map (offset = addr[6:0], in window when addr[31:7]==BASE_ADDR[31:7]):
//     0x00 CTRL     [0] GEN global enable; [16+i] CH_EN[i]; other bits read 0
//     0x04 PRESCALE [15:0] PSC; tick every PSC+1 clocks
//     0x08 STATUS   RO [PWM_BITS-1:0] current counter; writes ignored
//     0x40+4*i DUTY[i] [PWM_BITS-1:0], shadow value; i>=NUM_CH reads 0 and ignores writes
//   Reset: all registers, counters, shadow and active duty = 0; rdata=0, hit=0; pwm_out = ACTIVE_LOW
//     (all pins inactive). Reset asserted mid-period gives the same state on the next edge.
//   Writes: sw writes the whole word. sb writes byte lane addr[1:0]. sh writes lane addr[1];
//     sh with addr[0]=1 and funct3 not in {000,001,010} are dropped. Bits above field width are discarded.
//   Reads: rdata <= mapped value of addr each cycle, with a 1-cycle latency. Unmapped offsets and
//     out-of-window addresses give 0 (hit=0 outside the window).
//   Prescaler: GEN=0 holds psc_cnt=0 and cnt=0. GEN=1: when psc_cnt==PSC, tick=1 and psc_cnt<=0;
//     otherwise psc_cnt++. PSC=0 gives a tick every clock.
//   Counter: on tick, cnt <= cnt+1 modulo 2^PWM_BITS. Period boundary = tick && cnt==all-ones.
//   Duty update: on a period boundary, active[i] <= shadow[i] for all channels.
//     Also immediate (next edge) when GEN=0 or CH_EN[i]=0.
//   A DUTY write on a boundary cycle: active takes the pre-write shadow; the new value applies next period.
//   Output: raw[i] = GEN & CH_EN[i] & (cnt < active[i]). pwm_out[i] <= raw[i] ^ ACTIVE_LOW, one cycle
//     after cnt. Duty 0 gives constant off. Duty all-ones gives on for 2^PWM_BITS-1 of 2^PWM_BITS ticks.
//   Clearing CH_EN[i] or GEN forces the pin inactive on the second edge after the write (write edge plus output register).
//   Writing PSC mid-count: if psc_cnt>new PSC, the counter wraps through 0xFFFF (no early tick).
//     Software clears GEN first to avoid this.
// STRUCTURE
//   Shared package: register offset localparams (PWM_CTRL, PWM_PSC, PWM_STATUS, PWM_DUTY0),
//     store funct3 codes (F3_SB, F3_SH, F3_SW), reused by memory's store path.
//   Sub-module pwm_channel (PWM_BITS): shadow/active duty, boundary load, compare, output register.
//   The top level holds decode, byte-lane merge, CTRL/PSC, prescaler, counter, read mux, and the channel generate loop.
//   Integration: the core top gates the memory write enable with ~in_window and muxes rdata when hit.
// TESTING
//   Reset: pulse reset for 1 cycle with ACTIVE_LOW=1 -> pwm_out=4'b1111, rdata=0, STATUS=0, all regs read 0.
//   Duty: PSC=0, DUTY0=0x40, CTRL=0x0001_0001 -> pin0 low for 64 of every 256 clocks. Other pins stay high.
//   Shadow: mid-period, write DUTY0=0xC0 -> pulse width stays 64 until the wrap. It is 192 from the next period.
//     A write on the exact boundary cycle applies one period later.
//   Prescale: PSC=3 -> STATUS advances once per 4 clocks, period 1024 clocks. GEN=0 -> STATUS=0 and pins inactive.
//   Sub-word: sb 0xAA at 0x41 into DUTY0=0 -> reads 0x0000_AA00 masked to PWM_BITS -> 0. sh at 0x43 is dropped.
//     funct3=3'b011 is dropped. Out-of-window sw -> no register changes, hit=0.
//   Extremes: duty=0 -> never active. Duty=0xFF -> exactly 1 inactive clock per 256.
//     Reset asserted mid-pulse -> pins inactive and counters 0 on the next edge.

Source files
------------

// File: rtl/mmio_pwm_bank_pkg.sv
// Shared definitions for the memory-mapped PWM bank: register offsets inside
// the 128-byte window, store funct3 codes, and the store byte-lane mask helper
// that the memory store path also uses.
package mmio_pwm_bank_pkg;

  localparam logic [6:0] PWM_CTRL   = 7'h00;
  localparam logic [6:0] PWM_PSC    = 7'h04;
  localparam logic [6:0] PWM_STATUS = 7'h08;
  localparam logic [6:0] PWM_DUTY0  = 7'h40;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Bit mask of the lanes a store touches. Misaligned halfword stores and
  // unknown store sizes give an all-zero mask, i.e. the store is dropped.
  function automatic logic [31:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0]  be;
    logic [31:0] m;
    be = '0;
    case (f3)
      F3_SB:   be = 4'b0001 << a;
      F3_SH:   if (!a[0]) be = a[1] ? 4'b1100 : 4'b0011;
      F3_SW:   be = 4'b1111;
      default: be = '0;
    endcase
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/mmio_pwm_bank_pwm_channel.sv
// One PWM channel: shadow duty (software-visible), active duty (used by the
// comparator), and the registered output pin.
//   clk_i/reset_i  clock, synchronous active-high reset
//   gen_i, en_i    global and per-channel enable
//   boundary_i     last tick of the period: active takes the shadow value
//   cnt_i          shared period counter
//   we_i, wdata_i  shadow write
//   shadow_o       shadow value for read-back
//   pwm_o          registered pin, polarity set by ACTIVE_LOW
module pwm_channel #(
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                gen_i,
  input  logic                en_i,
  input  logic                boundary_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic                we_i,
  input  logic [PWM_BITS-1:0] wdata_i,
  output logic [PWM_BITS-1:0] shadow_o,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] shadow_q, shadow_d, active_q, active_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    shadow_d = we_i ? wdata_i : shadow_q;
    // Active follows the shadow at the period wrap, or at once while the
    // channel is idle. A shadow write on the wrap cycle is not seen until
    // the next wrap because active reads the registered shadow.
    active_d = (boundary_i || !gen_i || !en_i) ? shadow_q : active_q;
    pwm_d    = (gen_i && en_i && (cnt_i < active_q)) ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= ACTIVE_LOW;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign shadow_o = shadow_q;
  assign pwm_o    = pwm_q;

endmodule

// File: rtl/mmio_pwm_bank.sv
// Memory-mapped N-channel PWM bank on the core data bus.
//   clk, reset  single clock, synchronous active-high reset
//   wr_en       store strobe; funct3 gives the store size
//   addr        shared read/write byte address; wdata store data (lane aligned)
//   rdata, hit  registered read data / in-window flag for last cycle's addr
//   pwm_out     registered PWM pins
module mmio_pwm_bank
  import mmio_pwm_bank_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          PWM_BITS   = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              hit,
  output logic [NUM_CH-1:0] pwm_out
);

  logic                              gen_q, gen_d;
  logic [NUM_CH-1:0]                 ch_en_q, ch_en_d;
  logic [15:0]                       psc_q, psc_d, psc_cnt_q, psc_cnt_d;
  logic [PWM_BITS-1:0]               cnt_q, cnt_d;
  logic [31:0]                       rdata_q, rd_val, ctrl_val, wr_mask, wr_word;
  logic                              hit_q;
  logic                              in_win, wr_hit, tick, boundary;
  logic [6:0]                        woff;
  logic [3:0]                        widx;
  logic [NUM_CH-1:0][PWM_BITS-1:0]   shadow;
  logic                              unused_bits;

  assign in_win = (addr[31:7] == BASE_ADDR[31:7]);
  assign woff   = {addr[6:2], 2'b00};
  assign widx   = addr[5:2];
  assign wr_hit = wr_en && in_win;

  always_comb begin
    ctrl_val                 = '0;
    ctrl_val[0]              = gen_q;
    ctrl_val[16 +: NUM_CH]   = ch_en_q;
  end

  // Read mux; also supplies the old word for the sub-word store merge.
  always_comb begin
    rd_val = '0;
    if (in_win) begin
      if (woff == PWM_CTRL)        rd_val = ctrl_val;
      else if (woff == PWM_PSC)    rd_val = {16'h0, psc_q};
      else if (woff == PWM_STATUS) rd_val = 32'(cnt_q);
      else if (addr[6]) begin
        for (int i = 0; i < NUM_CH; i++)
          if (widx == 4'(i)) rd_val = 32'(shadow[i]);
      end
    end
  end

  assign wr_mask = store_mask(funct3, addr[1:0]);
  assign wr_word = (rd_val & ~wr_mask) | (wdata & wr_mask);
  // Bits of the merged word above each field width are discarded.
  assign unused_bits = ^wr_word;

  assign tick     = gen_q && (psc_cnt_q == psc_q);
  assign boundary = tick && (cnt_q == '1);

  always_comb begin
    gen_d   = gen_q;
    ch_en_d = ch_en_q;
    psc_d   = psc_q;
    if (wr_hit && woff == PWM_CTRL) begin
      gen_d   = wr_word[0];
      ch_en_d = wr_word[16 +: NUM_CH];
    end
    if (wr_hit && woff == PWM_PSC) psc_d = wr_word[15:0];
    // Lowering PSC below psc_cnt lets psc_cnt run on through 0xFFFF.
    if (!gen_q)    psc_cnt_d = '0;
    else if (tick) psc_cnt_d = '0;
    else           psc_cnt_d = psc_cnt_q + 16'd1;
    if (!gen_q)    cnt_d = '0;
    else if (tick) cnt_d = cnt_q + PWM_BITS'(1);
    else           cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_q     <= 1'b0;
      ch_en_q   <= '0;
      psc_q     <= '0;
      psc_cnt_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
    end else begin
      gen_q     <= gen_d;
      ch_en_q   <= ch_en_d;
      psc_q     <= psc_d;
      psc_cnt_q <= psc_cnt_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rd_val;
      hit_q     <= in_win;
    end
  end

  assign rdata = rdata_q;
  assign hit   = hit_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_ch (
      .clk_i      (clk),
      .reset_i    (reset),
      .gen_i      (gen_q),
      .en_i       (ch_en_q[i]),
      .boundary_i (boundary),
      .cnt_i      (cnt_q),
      .we_i       (wr_hit && addr[6] && widx == 4'(i)),
      .wdata_i    (wr_word[PWM_BITS-1:0]),
      .shadow_o   (shadow[i]),
      .pwm_o      (pwm_out[i])
    );
  end

endmodule
